// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared state encoding and width helpers for the branch resolve unit
package bru_pkg;

    typedef logic [0:0] bru_state_t;

    localparam bru_state_t ST_RUN   = 1'b0;
    localparam bru_state_t ST_STALL = 1'b1;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A zero penalty still needs a one-bit counter so the port widths stay legal.
    function automatic int stall_width(input int penalty);
        return (penalty > 0) ? $clog2(penalty + 1) : 1;
    endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// rtl/bru_pred_fifo.sv - 1-bit prediction FIFO with push, pop and wrong-path flush
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic                          head_data,
    output logic                          full,
    output logic                          empty,
    output logic [occ_width(DEPTH)-1:0]   count
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Flush discards everything, including a push arriving in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - matches in-flight predictions to outcomes, drives predictor updates and mispredict stalls
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int STALL_PENALTY = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    output logic                         pred_ready,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    output logic                         update_enable,
    output logic                         actual_taken,
    output logic                         mispredict,
    output logic                         stall,
    output logic [occ_width(DEPTH)-1:0]  inflight,
    output logic [CNT_WIDTH-1:0]         branch_count,
    output logic [CNT_WIDTH-1:0]         mispredict_count,
    output logic [CNT_WIDTH-1:0]         stall_cycles,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int  SW        = stall_width(STALL_PENALTY);
    localparam bit  HAS_STALL = (STALL_PENALTY > 0);

    bru_state_t     state;
    logic [SW-1:0]  stall_left;
    logic           full;
    logic           empty;
    logic           head_taken;
    logic           push_fire;
    logic           pop_fire;
    logic           wrong_dir;

    assign pred_ready = !full && (state == ST_RUN);
    assign push_fire  = pred_valid && pred_ready;
    assign pop_fire   = resolve_valid && !empty && (state == ST_RUN);
    assign wrong_dir  = pop_fire && (head_taken != resolve_taken);
    assign stall      = (state == ST_STALL);

    bru_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_fire),
        .push_data (pred_taken),
        .pop       (pop_fire),
        .flush     (wrong_dir),
        .head_data (head_taken),
        .full      (full),
        .empty     (empty),
        .count     (inflight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            update_enable <= 1'b0;
            actual_taken  <= 1'b0;
            mispredict    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            update_enable <= pop_fire;
            actual_taken  <= pop_fire ? resolve_taken : 1'b0;
            mispredict    <= wrong_dir;
            if (pred_valid && !pred_ready) begin
                overflow_err <= 1'b1;
            end
            // During STALL the FIFO is empty, so any resolve lands here too.
            if (resolve_valid && !pop_fire) begin
                underflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
            stall_cycles     <= '0;
        end else begin
            if (pop_fire && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (wrong_dir && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
            if ((state == ST_STALL) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            stall_left <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (wrong_dir && HAS_STALL) begin
                        state      <= ST_STALL;
                        stall_left <= SW'(STALL_PENALTY);
                    end
                end
                ST_STALL: begin
                    stall_left <= stall_left - SW'(1);
                    if (stall_left == SW'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    stall_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int P     = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pv, pt, rv, rt;
    logic        pred_ready, update_enable, actual_taken, mispredict, stall;
    logic [2:0]  inflight;
    logic [31:0] branch_count, mispredict_count, stall_cycles;
    logic        overflow_err, underflow_err;

    logic        pv0, pt0, rv0, rt0;
    logic        pred_ready0, update_enable0, actual_taken0, mispredict0, stall0;
    logic [2:0]  inflight0;
    logic [31:0] branch_count0, mispredict_count0, stall_cycles0;
    logic        overflow_err0, underflow_err0;

    branch_resolve_unit #(.DEPTH(DEPTH), .STALL_PENALTY(P), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pv), .pred_taken(pt), .pred_ready(pred_ready),
        .resolve_valid(rv), .resolve_taken(rt),
        .update_enable(update_enable), .actual_taken(actual_taken),
        .mispredict(mispredict), .stall(stall), .inflight(inflight),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .stall_cycles(stall_cycles),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    branch_resolve_unit #(.DEPTH(DEPTH), .STALL_PENALTY(0), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst),
        .pred_valid(pv0), .pred_taken(pt0), .pred_ready(pred_ready0),
        .resolve_valid(rv0), .resolve_taken(rt0),
        .update_enable(update_enable0), .actual_taken(actual_taken0),
        .mispredict(mispredict0), .stall(stall0), .inflight(inflight0),
        .branch_count(branch_count0), .mispredict_count(mispredict_count0),
        .stall_cycles(stall_cycles0),
        .overflow_err(overflow_err0), .underflow_err(underflow_err0)
    );

    typedef struct {
        logic taken;
        logic mis;
    } exp_t;

    exp_t sb[$];
    bit   m_q[$];
    int   m_left, m_br, m_mis, m_stc, stall_hits;
    bit   m_ovf, m_unf;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit p_v, input bit p_t, input bit r_v, input bit r_t);
        bit   ready, fire_pop, mis;
        exp_t e;
        ready    = (m_q.size() < DEPTH) && (m_left == 0);
        fire_pop = r_v && (m_q.size() > 0) && (m_left == 0);
        mis      = 1'b0;
        pv = p_v; pt = p_t; rv = r_v; rt = r_t;
        check("pred_ready", pred_ready, ready);
        if (p_v && !ready) m_ovf = 1'b1;
        if (r_v && !fire_pop) m_unf = 1'b1;
        if (fire_pop) begin
            mis = (m_q[0] != r_t);
            void'(m_q.pop_front());
            m_br++;
            e.taken = r_t;
            e.mis   = mis;
            sb.push_back(e);
        end
        if (mis) begin
            m_q.delete();
            m_mis++;
        end else if (p_v && ready) begin
            m_q.push_back(p_t);
        end
        if (m_left > 0) begin
            m_stc++;
            m_left--;
        end
        if (mis) m_left = P;

        @(posedge clk);
        #1;
        pv = 1'b0; rv = 1'b0;

        if (update_enable === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_update", update_enable, 0);
            end else begin
                e = sb.pop_front();
                check("actual_taken", actual_taken, e.taken);
                check("mispredict", mispredict, e.mis);
            end
        end else begin
            if (sb.size() != 0) begin
                check("missing_update", update_enable, 1);
                sb.delete();
            end
            check("mispredict_idle", mispredict, 0);
        end
        check("stall", stall, (m_left > 0));
        if (stall === 1'b1) stall_hits++;
        check("inflight", inflight, m_q.size());
        check("branch_count", branch_count, m_br);
        check("mispredict_count", mispredict_count, m_mis);
        check("stall_cycles", stall_cycles, m_stc);
        check("overflow_err", overflow_err, m_ovf);
        check("underflow_err", underflow_err, m_unf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pv = 1'b0; pt = 1'b0; rv = 1'b0; rt = 1'b0;
        pv0 = 1'b0; pt0 = 1'b0; rv0 = 1'b0; rt0 = 1'b0;
        @(posedge clk);
        #1;
        m_q.delete();
        sb.delete();
        m_left = 0; m_br = 0; m_mis = 0; m_stc = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        check("rst_update_enable", update_enable, 0);
        check("rst_actual_taken", actual_taken, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_stall", stall, 0);
        check("rst_inflight", inflight, 0);
        check("rst_branch_count", branch_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_overflow_err", overflow_err, 0);
        check("rst_underflow_err", underflow_err, 0);
        check("rst_pred_ready", pred_ready, 1);
        check("rst_pred_ready0", pred_ready0, 1);
        check("rst_stall_cycles0", stall_cycles0, 0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset and the 50-branch CPI pattern: every 4th branch mispredicts.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(1, 1, 0, 0);
            step(0, 0, 1, (i % 4) != 3);
            while (m_left > 0) step(0, 0, 0, 0);
        end
        check("cpi_branch_count", branch_count, 50);
        check("cpi_mispredict_count", mispredict_count, 12);
        check("cpi_stall_cycles", stall_cycles, 60);
        check("cpi_overflow_err", overflow_err, 0);
        check("cpi_underflow_err", underflow_err, 0);

        // Overflow when full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, i % 2, 0, 0);
        check("full_pred_ready", pred_ready, 0);
        step(1, 1, 0, 0);
        check("full_overflow_err", overflow_err, 1);
        check("full_inflight", inflight, 4);

        // Mispredict pop with a simultaneous push.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        stall_hits = 0;
        step(1, 1, 1, 0);
        check("flush_inflight", inflight, 0);
        check("flush_mispredict", mispredict, 1);
        check("flush_overflow_err", overflow_err, 0);
        while (m_left > 0) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("flush_stall_hits", stall_hits, 5);
        check("flush_mispredict_count", mispredict_count, 1);

        // Resolve with an empty FIFO.
        step(0, 0, 1, 1);
        check("underflow_no_update", update_enable, 0);
        check("underflow_branch_count", branch_count, 1);
        check("underflow_flag", underflow_err, 1);

        // Zero-penalty instance: flush only.
        pv0 = 1'b1; pt0 = 1'b1;
        @(posedge clk); #1;
        pv0 = 1'b0;
        check("p0_inflight_push", inflight0, 1);
        rv0 = 1'b1; rt0 = 1'b0;
        @(posedge clk); #1;
        rv0 = 1'b0;
        check("p0_mispredict", mispredict0, 1);
        check("p0_update_enable", update_enable0, 1);
        check("p0_actual_taken", actual_taken0, 0);
        check("p0_inflight", inflight0, 0);
        check("p0_stall", stall0, 0);
        check("p0_mispredict_count", mispredict_count0, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("p0_stall_idle", stall0, 0);
            check("p0_pred_ready", pred_ready0, 1);
            check("p0_mispredict_idle", mispredict0, 0);
        end
        check("p0_stall_cycles", stall_cycles0, 0);

        // Reset landing on the second stall cycle.
        do_reset();
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("midstall_stall", stall, 1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
